// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the ID-stage scoreboard slice.
//   NREG        number of architectural registers (x0 is hard-wired zero)
//   REG_W       register index width
//   OP_*        RV32I major opcodes
//   src_use()   which source register fields an opcode actually reads
package rv_pkg;

  localparam int NREG  = 32;
  localparam int REG_W = 5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RS1,
    SRC_BOTH
  } src_use_e;

  // Unknown opcodes read nothing, so they can never be held up by a source hazard.
  function automatic src_use_e src_use(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_S, OP_SB:        return SRC_BOTH;
      OP_LOAD, OP_IMM, OP_JALR: return SRC_RS1;
      default:                  return SRC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter.
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   inc           one write to this register issues this cycle
//   dec_a, dec_b  one write retires this cycle (writeback / kill)
//   cnt           current pending count
//   sat           count is all ones; no further issue may target this register
//   deficit       decrements that found nothing to retire (0 in legal operation)
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic [1:0]       deficit
);

  // Two extra bits: one for the +1 carry, one as a sign for up to -2.
  localparam int SUM_W = CNT_W + 2;

  logic [SUM_W-1:0] sum;
  logic             underflow;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise the tool infers a latch to hold the old value.
  always_comb begin
    sum       = SUM_W'(cnt) + SUM_W'(inc) - SUM_W'(dec_a) - SUM_W'(dec_b);
    underflow = sum[SUM_W-1];
    deficit   = underflow ? 2'(-sum) : 2'd0;
  end

  assign sat = &cnt;

  // NOTE: the scoreboard lives in flops, not a RAM, so every counter can be
  // cleared asynchronously by reset in a single event.
  // NOTE: state registers use non-blocking assignment so all counters update
  // from the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= underflow ? '0 : sum[CNT_W-1:0];
  end

  // Retiring a write that was never issued points at a pipeline bug upstream.
  assert property (@(posedge clock) disable iff (!reset) !underflow)
    else $error("sb_counter: decrement of an empty pending counter");

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard and stall generator.
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   id_*                   instruction currently in ID
//   wb_valid, wb_rd        register write committing this cycle
//   kill_valid, kill_rd    in-flight writer squashed this cycle
//   stall                  ID instruction must not issue
//   pc_load, if_id_load    front-end register enables (~stall)
//   bubble_sel             ID/EX loads a NOP
//   busy_vec               per-register "write pending" flags (bit 0 always 0)
//   infl_cnt               total pending writes
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int CNT_W     = 2,
  parameter int MAX_INFL  = 3,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             kill_valid,
  input  logic [REG_W-1:0] kill_rd,
  output logic             stall,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             bubble_sel,
  output logic [NREG-1:0]  busy_vec,
  output logic [2:0]       infl_cnt
);

  logic [CNT_W-1:0] cnt     [NREG];
  logic [1:0]       deficit [NREG];
  logic [NREG-1:0]  sat_vec;

  logic             wb_ret, kill_ret, issue;
  logic             use_rs1, use_rs2;
  logic             haz_rs1, haz_rs2, rd_sat, infl_full;
  logic [2:0]       deficit_sum, infl_nxt;
  src_use_e         src;

  assign wb_ret   = wb_valid && (wb_rd != '0);
  assign kill_ret = kill_valid && (kill_rd != '0);

  // x0 is never tracked: its slot reads as permanently idle.
  assign cnt[0]     = '0;
  assign deficit[0] = '0;
  assign sat_vec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (issue && (id_rd == REG_W'(r))),
      .dec_a   (wb_ret && (wb_rd == REG_W'(r))),
      .dec_b   (kill_ret && (kill_rd == REG_W'(r))),
      .cnt     (cnt[r]),
      .sat     (sat_vec[r]),
      .deficit (deficit[r])
    );
  end

  always_comb begin
    src     = src_use(id_opcode);
    use_rs1 = (src != SRC_NONE);
    use_rs2 = (src == SRC_BOTH);

    // A write-first register file hands the last pending value straight to
    // the reader, so the final outstanding write committing now is no hazard.
    haz_rs1 = use_rs1 && (id_rs1 != '0) && (cnt[id_rs1] != '0) &&
              !(WB_BYPASS && (cnt[id_rs1] == CNT_W'(1)) && wb_valid && (wb_rd == id_rs1));
    haz_rs2 = use_rs2 && (id_rs2 != '0) && (cnt[id_rs2] != '0) &&
              !(WB_BYPASS && (cnt[id_rs2] == CNT_W'(1)) && wb_valid && (wb_rd == id_rs2));

    rd_sat    = id_regwrite && (id_rd != '0) && sat_vec[id_rd];
    // A retire in the same cycle frees a slot, so a full pipeline need not stall.
    infl_full = (infl_cnt == 3'(MAX_INFL)) && !wb_ret && !kill_ret;

    stall = id_valid && (haz_rs1 || haz_rs2 || rd_sat || infl_full);
    issue = id_valid && !stall && id_regwrite && (id_rd != '0);
  end

  assign pc_load    = ~stall;
  assign if_id_load = ~stall;
  assign bubble_sel = stall;

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt[r] != '0);
  end

  // Only the counters addressed by wb_rd / kill_rd can fall short; adding
  // their shortfall back keeps infl_cnt equal to the sum of the counters.
  always_comb begin
    deficit_sum = 3'(deficit[wb_rd]) + ((kill_rd != wb_rd) ? 3'(deficit[kill_rd]) : 3'd0);
    infl_nxt    = infl_cnt + 3'(issue) - 3'(wb_ret) - 3'(kill_ret) + deficit_sum;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) infl_cnt <= '0;
    else        infl_cnt <= infl_nxt;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a counting reference model.
module tb_reg_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        stall, pc_load, if_id_load, bubble_sel;
  logic [31:0] busy_vec;
  logic [2:0]  infl_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: pending writes per register.
  int m_cnt [32];
  int avail [32];

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LUI  = 7'b0110111;

  logic [6:0] ops [10] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0000011, 7'b0010011,
                           7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};

  reg_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .kill_valid  (kill_valid),
    .kill_rd     (kill_rd),
    .stall       (stall),
    .pc_load     (pc_load),
    .if_id_load  (if_id_load),
    .bubble_sel  (bubble_sel),
    .busy_vec    (busy_vec),
    .infl_cnt    (infl_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_infl();
    int s;
    s = 0;
    for (int r = 0; r < 32; r++) s += m_cnt[r];
    return s;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  function automatic bit m_src_haz(input logic [4:0] rs);
    int c;
    c = m_cnt[rs];
    if (rs == 0 || c == 0) return 1'b0;
    if (c == 1 && wb_valid && wb_rd == rs) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit u1, u2;
    case (id_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin u1 = 1'b1; u2 = 1'b1; end
      7'b0000011, 7'b0010011, 7'b1100111: begin u1 = 1'b1; u2 = 1'b0; end
      default:                            begin u1 = 1'b0; u2 = 1'b0; end
    endcase
    if (!id_valid) return 1'b0;
    if (u1 && m_src_haz(id_rs1)) return 1'b1;
    if (u2 && m_src_haz(id_rs2)) return 1'b1;
    if (id_regwrite && id_rd != 0 && m_cnt[id_rd] == 3) return 1'b1;
    if (m_infl() == 3 && !(wb_valid && wb_rd != 0) && !(kill_valid && kill_rd != 0)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
  endtask

  task automatic m_update();
    bit st;
    if (!reset) begin
      m_clear();
    end else begin
      st = m_stall();
      if (id_valid && !st && id_regwrite && id_rd != 0) m_cnt[id_rd]++;
      if (wb_valid && wb_rd != 0) m_cnt[wb_rd]--;
      if (kill_valid && kill_rd != 0) m_cnt[kill_rd]--;
    end
  endtask

  task automatic set_id(input bit v, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input bit rw);
    id_valid = v; id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_regwrite = rw;
  endtask

  task automatic set_wb(input bit v, input logic [4:0] rd);
    wb_valid = v; wb_rd = rd;
  endtask

  task automatic set_kill(input bit v, input logic [4:0] rd);
    kill_valid = v; kill_rd = rd;
  endtask

  task automatic idle();
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_wb(1'b0, 5'd0);
    set_kill(1'b0, 5'd0);
  endtask

  // Compare every output against the model, mid-cycle on the falling edge.
  task automatic sample();
    bit s;
    @(negedge clock);
    s = m_stall();
    check("stall",      32'(stall),      32'(s));
    check("pc_load",    32'(pc_load),    32'(!s));
    check("if_id_load", 32'(if_id_load), 32'(!s));
    check("bubble_sel", 32'(bubble_sel), 32'(s));
    check("busy_vec",   busy_vec,        m_busy());
    check("infl_cnt",   32'(infl_cnt),   32'(m_infl()));
  endtask

  task automatic advance();
    @(posedge clock);
    m_update();
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  function automatic int pick_busy();
    int q[$];
    for (int r = 1; r < 32; r++) if (avail[r] > 0) q.push_back(r);
    if (q.size() == 0) return 0;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  initial begin
    int r;
    m_clear();
    reset = 1'b0;
    idle();

    // Reset state, then release away from the rising edge.
    sample();
    @(posedge clock);
    #1 reset = 1'b1;
    sample();
    check("t1_stall", 32'(stall), 32'd0);
    check("t1_pc_load", 32'(pc_load), 32'd1);
    check("t1_busy", busy_vec, 32'd0);
    advance();

    // RAW hazard on x5, resolved by same-cycle writeback.
    set_id(1'b1, ADD, 5'd0, 5'd0, 5'd5, 1'b1);
    cycle();
    set_id(1'b1, ADD, 5'd5, 5'd6, 5'd10, 1'b1);
    sample();
    check("t2_stall", 32'(stall), 32'd1);
    check("t2_bubble", 32'(bubble_sel), 32'd1);
    advance();
    set_wb(1'b1, 5'd5);
    sample();
    check("t2_bypass_stall", 32'(stall), 32'd0);
    advance();

    // In-flight limit, relieved by a same-cycle retire.
    idle();
    set_wb(1'b1, 5'd10);
    cycle();
    idle();
    for (int i = 1; i <= 3; i++) begin
      set_id(1'b1, ADDI, 5'd0, 5'd0, 5'(i), 1'b1);
      cycle();
    end
    set_id(1'b1, ADDI, 5'd0, 5'd0, 5'd4, 1'b1);
    sample();
    check("t3_infl3", 32'(infl_cnt), 32'd3);
    check("t3_full_stall", 32'(stall), 32'd1);
    advance();
    set_wb(1'b1, 5'd1);
    sample();
    check("t3_retire_stall", 32'(stall), 32'd0);
    advance();
    idle();
    sample();
    check("t3_infl_stays", 32'(infl_cnt), 32'd3);
    advance();

    // Issue, writeback and kill on the same register in one cycle.
    for (int i = 2; i <= 4; i++) begin
      set_wb(1'b1, 5'(i));
      cycle();
    end
    idle();
    set_id(1'b1, ADDI, 5'd0, 5'd0, 5'd7, 1'b1);
    cycle();
    cycle();
    set_wb(1'b1, 5'd7);
    set_kill(1'b1, 5'd7);
    cycle();
    idle();
    sample();
    check("t4_busy", busy_vec, 32'h0000_0080);
    check("t4_infl", 32'(infl_cnt), 32'd1);
    advance();

    // LUI ignores its rs1 field; writes to x0 are not tracked.
    set_id(1'b1, ADDI, 5'd0, 5'd0, 5'd5, 1'b1);
    cycle();
    set_id(1'b1, LUI, 5'd5, 5'd5, 5'd9, 1'b1);
    sample();
    check("t5_lui_stall", 32'(stall), 32'd0);
    advance();
    idle();
    set_wb(1'b1, 5'd9);
    cycle();
    idle();
    set_id(1'b1, ADDI, 5'd0, 5'd0, 5'd0, 1'b1);
    sample();
    check("t5_x0_stall", 32'(stall), 32'd0);
    advance();
    idle();
    sample();
    check("t5_x0_busy", busy_vec, 32'h0000_00a0);
    check("t5_x0_infl", 32'(infl_cnt), 32'd2);
    advance();

    // Asynchronous reset with writes pending on x3 and x8.
    set_wb(1'b1, 5'd5);
    cycle();
    set_wb(1'b1, 5'd7);
    cycle();
    idle();
    set_id(1'b1, ADDI, 5'd0, 5'd0, 5'd3, 1'b1);
    cycle();
    set_id(1'b1, ADDI, 5'd0, 5'd0, 5'd8, 1'b1);
    cycle();
    idle();
    sample();
    check("t6_busy_before", busy_vec, 32'h0000_0108);
    #2 reset = 1'b0;
    #1;
    check("t6_busy_async", busy_vec, 32'd0);
    check("t6_infl_async", 32'(infl_cnt), 32'd0);
    m_clear();
    @(posedge clock);
    #1 reset = 1'b1;
    set_id(1'b1, ADD, 5'd3, 5'd8, 5'd11, 1'b1);
    sample();
    check("t6_first_issue", 32'(stall), 32'd0);
    advance();
    idle();
    set_wb(1'b1, 5'd11);
    cycle();

    // Randomized traffic; retires only target registers the model holds as pending.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 32; k++) avail[k] = m_cnt[k];
      set_id($urandom_range(0, 9) < 8, ops[$urandom_range(0, 9)],
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      set_wb(1'b0, 5'd0);
      set_kill(1'b0, 5'd0);
      r = pick_busy();
      if (r != 0 && $urandom_range(0, 2) == 0) begin
        set_wb(1'b1, 5'(r));
        avail[r]--;
      end else if ($urandom_range(0, 7) == 0) begin
        set_wb(1'b1, 5'd0);
      end
      r = pick_busy();
      if (r != 0 && $urandom_range(0, 4) == 0) set_kill(1'b1, 5'(r));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
